// File: rtl/exposure_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exposure_ctrl
// Brief    : Capture sequencer: exposure setting, timer handshake and
//            two-row pixel readout with ADC strobes.
// Revision : 1.0
// ============================================================================
module exposure_ctrl #(
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_init,
    input  logic       i_exp_increase,
    input  logic       i_exp_decrease,
    input  logic       i_ex_done,
    output logic       o_ex_set,
    output logic       o_ex_start,
    output logic [4:0] o_exp_time,
    output logic       o_erase,
    output logic       o_expose,
    output logic       o_nre_1,
    output logic       o_nre_2,
    output logic       o_adc,
    output logic       o_busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SET     = 2'd1;
    localparam logic [1:0] c_EXPOSE  = 2'd2;
    localparam logic [1:0] c_READOUT = 2'd3;

    localparam logic [4:0] c_EXP_MIN     = EXP_MIN[4:0];
    localparam logic [4:0] c_EXP_MAX     = EXP_MAX[4:0];
    localparam logic [4:0] c_EXP_DEFAULT = EXP_DEFAULT[4:0];
    localparam logic [2:0] c_STEP_LAST   = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_step;
    logic [4:0] r_exp_time;
    logic       r_inc_prev;
    logic       r_dec_prev;
    logic       r_inc_edge;
    logic       r_dec_edge;

    logic       w_adjust;
    logic       w_inc_only;
    logic       w_dec_only;
    logic       w_readout;

    // Edges detected while not idle are dropped, not queued for later.
    assign w_adjust   = (r_state == c_IDLE) && !i_init;
    assign w_inc_only = r_inc_edge && !r_dec_edge;
    assign w_dec_only = r_dec_edge && !r_inc_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inc_prev <= 1'b0;
            r_dec_prev <= 1'b0;
            r_inc_edge <= 1'b0;
            r_dec_edge <= 1'b0;
        end else begin
            r_inc_prev <= i_exp_increase;
            r_dec_prev <= i_exp_decrease;
            r_inc_edge <= i_exp_increase && !r_inc_prev;
            r_dec_edge <= i_exp_decrease && !r_dec_prev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exp_time <= c_EXP_DEFAULT;
        end else if (w_adjust && w_inc_only) begin
            if (r_exp_time >= c_EXP_MAX) begin
                r_exp_time <= c_EXP_MAX;
            end else begin
                r_exp_time <= r_exp_time + 5'd1;
            end
        end else if (w_adjust && w_dec_only) begin
            if (r_exp_time <= c_EXP_MIN) begin
                r_exp_time <= c_EXP_MIN;
            end else begin
                r_exp_time <= r_exp_time - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_step  <= 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_init) begin
                        r_state <= c_SET;
                    end
                end
                c_SET: begin
                    r_state <= c_EXPOSE;
                end
                c_EXPOSE: begin
                    if (i_ex_done) begin
                        r_state <= c_READOUT;
                        r_step  <= 3'd0;
                    end
                end
                c_READOUT: begin
                    if (r_step == c_STEP_LAST) begin
                        r_state <= c_IDLE;
                        r_step  <= 3'd0;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_step  <= 3'd0;
                end
            endcase
        end
    end

    // Pure decode of registered state so reset drives outputs immediately.
    assign w_readout  = (r_state == c_READOUT);
    assign o_busy     = (r_state != c_IDLE);
    assign o_erase    = (r_state == c_IDLE);
    assign o_ex_set   = (r_state == c_SET);
    assign o_ex_start = (r_state == c_EXPOSE);
    assign o_expose   = (r_state == c_EXPOSE);
    assign o_exp_time = r_exp_time;
    assign o_nre_1    = !(w_readout && (r_step <= 3'd2));
    assign o_nre_2    = !(w_readout && (r_step >= 3'd4) && (r_step <= 3'd6));
    assign o_adc      = w_readout && ((r_step == 3'd1) || (r_step == 3'd5));

endmodule
`default_nettype wire

// File: tb/tb_exposure_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exposure_ctrl
// Brief    : Self-checking bench for exposure_ctrl with a capture-level model
//            and a behavioural timer counter.
// Revision : 1.0
// ============================================================================
module tb_exposure_ctrl;

    localparam int c_MIN = 2;
    localparam int c_MAX = 30;
    localparam int c_DEF = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       force_done = 1'b0;
    logic       ex_done;
    logic       ex_set, ex_start, erase, expose, nre_1, nre_2, adc, busy;
    logic [4:0] exp_time;
    logic [5:0] tmr_cnt = 6'd0;

    int  errs = 0;
    int  checks = 0;
    bit  cmp_en = 1'b0;

    exposure_ctrl #(.EXP_MIN(c_MIN), .EXP_MAX(c_MAX), .EXP_DEFAULT(c_DEF)) dut (
        .clk(clk), .reset_n(reset_n), .i_init(init),
        .i_exp_increase(inc), .i_exp_decrease(dec), .i_ex_done(ex_done),
        .o_ex_set(ex_set), .o_ex_start(ex_start), .o_exp_time(exp_time),
        .o_erase(erase), .o_expose(expose), .o_nre_1(nre_1), .o_nre_2(nre_2),
        .o_adc(adc), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Timer counter: no reset, loads init+1, counts down while enabled.
    always @(posedge clk) begin
        if (ex_set) tmr_cnt <= {1'b0, exp_time} + 6'd1;
        else if (ex_start && tmr_cnt != 6'd0) tmr_cnt <= tmr_cnt - 6'd1;
    end
    assign ex_done = (tmr_cnt == 6'd0) || force_done;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: m_k = cycle position inside a capture (0 idle, 1 set, >=2 after),
    // m_rd = readout index once readout has started, -1 before.
    int m_k = 0, m_rd = -1, m_exp = c_DEF;
    bit m_inc_prev = 0, m_dec_prev = 0, m_inc_edge = 0, m_dec_edge = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_k = 0; m_rd = -1; m_exp = c_DEF;
            m_inc_prev = 0; m_dec_prev = 0; m_inc_edge = 0; m_dec_edge = 0;
        end else begin
            if (m_k == 0 && !init && m_inc_edge != m_dec_edge)
                m_exp = m_inc_edge ? ((m_exp + 1 > c_MAX) ? c_MAX : m_exp + 1)
                                   : ((m_exp - 1 < c_MIN) ? c_MIN : m_exp - 1);
            if (m_k == 0) begin
                if (init) m_k = 1;
            end else if (m_k == 1) begin
                m_k = 2;
            end else if (m_rd < 0) begin
                if (ex_done) m_rd = 0;
                m_k++;
            end else if (m_rd == 7) begin
                m_k = 0; m_rd = -1;
            end else begin
                m_rd++; m_k++;
            end
            m_inc_edge = inc && !m_inc_prev;
            m_dec_edge = dec && !m_dec_prev;
            m_inc_prev = inc;
            m_dec_prev = dec;
        end
    end

    always @(negedge clk) begin
        if (reset_n && cmp_en) begin
            chk("m_busy", busy, m_k != 0);
            chk("m_erase", erase, m_k == 0);
            chk("m_ex_set", ex_set, m_k == 1);
            chk("m_expose", expose, m_k >= 2 && m_rd < 0);
            chk("m_ex_start", ex_start, m_k >= 2 && m_rd < 0);
            chk("m_exp_time", exp_time, m_exp);
            chk("m_nre_1", nre_1, !(m_rd >= 0 && m_rd <= 2));
            chk("m_nre_2", nre_2, !(m_rd >= 4 && m_rd <= 6));
            chk("m_adc", adc, m_rd == 1 || m_rd == 5);
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_capture(input int e_len, input string tag);
        int n_set = 0, n_exp = 0, n_busy = 0, n_n1 = 0, n_n2 = 0;
        int a1 = -1, a2 = -1;
        bit done = 0;
        @(posedge clk); #1 init = 1;
        @(posedge clk); #1 init = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
            if (ex_set) n_set++;
            if (expose) n_exp++;
            if (!nre_1) n_n1++;
            if (!nre_2) n_n2++;
            if (adc) begin if (a1 < 0) a1 = n_busy; else a2 = n_busy; end
            n_busy++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ex_set_len"}, n_set, 1);
        chk({tag, "_expose_len"}, n_exp, e_len);
        chk({tag, "_busy_len"}, n_busy, e_len + 9);
        chk({tag, "_nre1_len"}, n_n1, 3);
        chk({tag, "_nre2_len"}, n_n2, 3);
        chk({tag, "_adc1_pos"}, a1, e_len + 2);
        chk({tag, "_adc2_pos"}, a2, e_len + 6);
    endtask

    task automatic pulse(input bit do_inc, input int n);
        repeat (n) begin
            @(posedge clk); #1 if (do_inc) inc = 1; else dec = 1;
            @(posedge clk); #1 inc = 0; dec = 0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int gaps, bad_gaps, idle_run, t0;
        bit seen_busy, ok;

        repeat (3) @(posedge clk);
        #1 reset_n = 1; cmp_en = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_exp_time", exp_time, 16);
        chk("rst_erase", erase, 1);
        chk("rst_busy", busy, 0);
        chk("rst_nre_1", nre_1, 1);
        chk("rst_nre_2", nre_2, 1);
        chk("rst_adc", adc, 0);

        run_capture(18, "cap_default");

        // Adjustment latency: raw rise, edge registered, then exp_time moves.
        @(posedge clk); #1 inc = 1;
        @(posedge clk); #1 chk("lat_1cyc", exp_time, 16);
        @(posedge clk); #1 chk("lat_2cyc", exp_time, 17); inc = 0;
        pulse(1, 20);
        chk("sat_max", exp_time, 30);
        pulse(0, 40);
        chk("sat_min", exp_time, 2);
        run_capture(4, "cap_min");

        pulse(1, 3);
        chk("up_to_5", exp_time, 5);
        @(posedge clk); #1 inc = 1; dec = 1;
        @(posedge clk); #1 inc = 0; dec = 0;
        repeat (3) @(posedge clk);
        #1 chk("both_edges", exp_time, 5);

        @(posedge clk); #1 inc = 1;
        @(posedge clk); #1 init = 1;
        @(posedge clk); #1 init = 0; inc = 0;
        wait_idle("inc_with_init");
        repeat (2) @(posedge clk);
        #1 chk("inc_with_init", exp_time, 5);

        @(posedge clk); #1 init = 1;
        @(posedge clk); #1 init = 0;
        ok = 0;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (expose) begin ok = 1; break; end
        end
        chk("reach_expose", ok, 1);
        inc = 1;
        wait_idle("inc_in_expose");
        repeat (4) @(posedge clk);
        #1 inc = 0;
        repeat (2) @(posedge clk);
        #1 chk("inc_in_expose", exp_time, 5);

        t0 = exp_time;
        gaps = 0; bad_gaps = 0; idle_run = 0; seen_busy = 0;
        @(posedge clk); #1 init = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (exp_time != 5'(t0)) bad_gaps++;
            if (busy) begin
                if (seen_busy && idle_run > 0) begin
                    gaps++;
                    if (idle_run != 1) bad_gaps++;
                end
                seen_busy = 1; idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        #1 init = 0;
        chk("b2b_gap_count", gaps, 3);
        chk("b2b_bad", bad_gaps, 0);
        wait_idle("b2b");

        @(posedge clk); #1 force_done = 1;
        repeat (3) @(posedge clk);
        #1 force_done = 0;
        chk("spur_idle_busy", busy, 0);
        @(posedge clk); #1 init = 1;
        @(posedge clk); #1 init = 0; force_done = 1;
        chk("spur_set_state", ex_set, 1);
        @(posedge clk); #1 force_done = 0;
        chk("spur_set_expose", expose, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 force_done = 1;
        @(posedge clk); #1 force_done = 0;
        chk("spur_exp_nre_1", nre_1, 0);
        chk("spur_exp_expose", expose, 0);
        @(posedge clk); #1 force_done = 1;
        @(posedge clk); #1 force_done = 0;
        chk("spur_ro_busy", busy, 1);
        chk("spur_ro_nre_1", nre_1, 0);
        wait_idle("spur");

        @(posedge clk); #1 init = 1;
        @(posedge clk); #1 init = 0;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_expose", expose, 1);
        @(negedge clk); #2 reset_n = 0;
        #1;
        chk("arst_exp_time", exp_time, 16);
        chk("arst_erase", erase, 1);
        chk("arst_expose", expose, 0);
        chk("arst_ex_set", ex_set, 0);
        chk("arst_ex_start", ex_start, 0);
        chk("arst_nre_1", nre_1, 1);
        chk("arst_nre_2", nre_2, 1);
        chk("arst_adc", adc, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1 reset_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_busy", busy, 0);
        run_capture(18, "cap_after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exposure_ctrl.md
# exposure_ctrl

- Capture sequencer for the camera datapath.
- It owns the exposure setting, handles the capture request, and adjusts the exposure time in steps.
- It drives the timer counter through its ex_set / ex_start / ex_done handshake, then runs a fixed two-row pixel readout with ADC strobes.
- It sits between the user-button inputs, the timer counter and the pixel array / ADC.

## Interface
- EXP_MIN, 2: minimum exposure setting; lower saturation bound.
- EXP_MAX, 30: maximum exposure setting; must be ≤ 30, because the timer loads init+1 into 5 bits.
- EXP_DEFAULT, 16: exposure setting after reset.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- init  input  1  capture request, level-sensitive, sampled only in IDLE.
- exp_increase  input  1  button; its rising edge raises the exposure setting by 1.
- exp_decrease  input  1  button; its rising edge lowers the exposure setting by 1.
- ex_done  input  1  from timer; high when the timer count is 0.
- ex_set  output  1  to timer; loads exp_time.
- ex_start  output  1  to timer; enables the countdown.
- exp_time  output  5  to timer init; current exposure setting.
- erase  output  1  holds the pixel array erased.
- expose  output  1  pixel integration enable.
- nre_1  output  1  row-1 read enable, active-low.
- nre_2  output  1  row-2 read enable, active-low.
- adc  output  1  ADC sample strobe.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SET, EXPOSE, READOUT.
- Outputs are a decode of the registered state and the readout step counter. There is no combinational input-to-output path.
- IDLE
  - Outputs: erase=1; all other controls inactive.
  - If init=1 at a clock edge: go to SET.
  - Otherwise apply exposure adjustment (rules below).
- SET
  - Outputs: ex_set=1, erase=0; lasts exactly one cycle.
  - Always goes to EXPOSE.
- EXPOSE
  - Outputs: expose=1, ex_start=1.
  - Go to READOUT when ex_done=1 is sampled.
  - The step counter clears on entry to READOUT.
- READOUT: 8 cycles, 3-bit step counter s = 0..7.
  - s=0..2: nre_1=0; at s=1 adc=1 as well.
  - s=3: gap, all read controls inactive.
  - s=4..6: nre_2=0; at s=5 adc=1 as well.
  - s=7: gap.
  - After s=7 go to IDLE.
- Exposure adjustment
  - Each button is registered once; an edge is the current sample high while the previous sample was low.
  - Adjustment applies only in IDLE, and only when init=0 in that cycle.
  - The edge registers update in every state, so a press that begins outside IDLE is consumed and never applied.
  - Increase edge alone: exp_time = min(exp_time+1, EXP_MAX).
  - Decrease edge alone: exp_time = max(exp_time-1, EXP_MIN).
  - Both edges in the same cycle: no change.
  - exp_time is held constant from SET through READOUT.
- init held high: on return to IDLE, the next capture starts one cycle later.
- ex_done is ignored outside EXPOSE.
- The timer has no reset. The controller never asserts ex_start without a preceding ex_set.

## Timing
- Reset (async, while reset_n=0) values:
  - state=IDLE, s=0, exp_time=EXP_DEFAULT.
  - erase=1, expose=0, ex_set=0, ex_start=0, nre_1=1, nre_2=1, adc=0, busy=0.
  - Button edge registers = 0.
- Reset asserted mid-capture: outputs return to the reset values immediately, without waiting for a clock.
- Deassertion takes effect at the first clock edge with reset_n=1.
- Capture latency:
  - init sampled at edge E: ex_set is high for the cycle after E.
  - expose rises at E+2.
- Exposure length:
  - The timer is loaded with exp_time+1.
  - ex_done rises exp_time+1 cycles into EXPOSE and is sampled one edge later.
  - So expose and ex_start are high for exactly exp_time+2 cycles.
- Readout: 8 cycles, then IDLE with erase=1.
- Total busy time per capture: 1 + (exp_time+2) + 8 = exp_time+11 cycles.
- Adjustment latency: exp_time updates one cycle after the button edge is detected, i.e. 2 cycles after the raw input rises.

## Test plan
- Reset then idle 5 cycles -> exp_time=16, erase=1, busy=0, nre_1=nre_2=1, adc=0; reset pulse mid-EXPOSE -> same values immediately.
- Default capture, init pulsed 1 cycle ->
  - ex_set high for 1 cycle.
  - expose and ex_start high for 18 cycles.
  - nre_1 low 3 cycles, 1 gap cycle, nre_2 low 3 cycles.
  - adc high at readout steps 1 and 5.
  - busy for 27 cycles.
- 20 exp_increase pulses -> exp_time saturates at 30; 40 exp_decrease pulses -> saturates at 2; capture at 2 -> expose high 4 cycles.
- Simultaneous increase+decrease edge -> no change; increase edge in the same cycle as init -> ignored; increase pressed during EXPOSE and held into IDLE -> no change.
- init held high for 60 cycles -> back-to-back captures with exactly 1 IDLE cycle between them; exp_time stays constant throughout.
- Spurious ex_done=1 during IDLE, SET or READOUT -> no state change; in EXPOSE -> READOUT on the next edge.
